// File: rtl/result_hps_sender_if.sv
// Handshake and data bundle between a result producer/HPS side and the
// result_hps_sender block. The sender uses the slave view.
interface result_hps_sender_if;
    logic         start;
    logic [1:0]   matrix_size;
    logic [199:0] matrix_result;
    logic         hps_ack;
    logic [7:0]   data_out;
    logic         data_valid;
    logic         busy;
    logic         done;

    modport master (
        output start, matrix_size, matrix_result, hps_ack,
        input  data_out, data_valid, busy, done
    );

    modport slave (
        input  start, matrix_size, matrix_result, hps_ack,
        output data_out, data_valid, busy, done
    );
endinterface

// File: rtl/result_hps_sender.sv
// Streams a captured matrix of signed 8-bit results to the HPS one element at
// a time, using a four-phase valid/ack handshake per element.
module result_hps_sender (
    input  logic                 clk,
    input  logic                 rst_n,
    result_hps_sender_if.slave   bus
);
    localparam logic [1:0] ST_IDLE         = 2'd0;
    localparam logic [1:0] ST_SEND         = 2'd1;
    localparam logic [1:0] ST_WAIT_ACK_LOW = 2'd2;
    localparam logic [1:0] ST_DONE         = 2'd3;

    logic [1:0]   state_q, state_d;
    logic [199:0] shift_q, shift_d;
    logic [4:0]   count_q, count_d;
    logic [7:0]   data_out_q, data_out_d;
    logic         data_valid_q, data_valid_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    // Next-state, capture, shift and count logic
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        count_d = count_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    shift_d = bus.matrix_result;
                    case (bus.matrix_size)
                        2'b00:   count_d = 5'd4;
                        2'b01:   count_d = 5'd9;
                        2'b10:   count_d = 5'd16;
                        2'b11:   count_d = 5'd25;
                        default: count_d = 5'd25;
                    endcase
                    state_d = ST_SEND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (bus.hps_ack) begin
                    state_d = ST_WAIT_ACK_LOW;
                end else begin
                    state_d = ST_SEND;
                end
            end
            ST_WAIT_ACK_LOW: begin
                if (bus.hps_ack) begin
                    state_d = ST_WAIT_ACK_LOW;
                end else if (count_q > 5'd1) begin
                    shift_d = {shift_q[191:0], 8'h00};
                    count_d = count_q - 5'd1;
                    state_d = ST_SEND;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state flop
    always_comb begin
        data_valid_d = 1'b0;
        data_out_d   = 8'h00;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        if (state_d == ST_SEND) begin
            data_valid_d = 1'b1;
            data_out_d   = shift_d[199:192];
        end else begin
            data_valid_d = 1'b0;
            data_out_d   = 8'h00;
        end
        if (state_d != ST_IDLE) begin
            busy_d = 1'b1;
        end else begin
            busy_d = 1'b0;
        end
        if (state_d == ST_DONE) begin
            done_d = 1'b1;
        end else begin
            done_d = 1'b0;
        end
    end

    // State, data and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            shift_q      <= 200'd0;
            count_q      <= 5'd0;
            data_out_q   <= 8'h00;
            data_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            count_q      <= count_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.data_valid = data_valid_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_result_hps_sender.sv
// Directed and randomized checks of result_hps_sender against an element-list
// reference model and a behavioural HPS acknowledge agent.
module tb_result_hps_sender;
    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    result_hps_sender_if hif ();

    result_hps_sender dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (hif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic v, input logic [7:0] d,
                           input logic b, input logic dn);
        chk({tag, ".data_valid"}, {31'd0, hif.data_valid}, {31'd0, v});
        chk({tag, ".data_out"},   {24'd0, hif.data_out},   {24'd0, d});
        chk({tag, ".busy"},       {31'd0, hif.busy},       {31'd0, b});
        chk({tag, ".done"},       {31'd0, hif.done},       {31'd0, dn});
    endtask

    function automatic logic [199:0] rand_mat();
        logic [199:0] m;
        m = 200'd0;
        for (int i = 0; i < 7; i++) m = (m << 32) | 200'($urandom);
        return m;
    endfunction

    // HPS agent: serve every element of an already-started transfer.
    // Called one negedge after the start edge.
    task automatic serve(input logic [1:0] sz, input logic [199:0] mat,
                         input int hold0, input bit mid_start);
        int n;
        int dly;
        int hold;
        logic [7:0] q[$];
        n = (int'(sz) + 2) * (int'(sz) + 2);
        for (int k = 0; k < n; k++) q.push_back(mat[199 - 8*k -: 8]);
        for (int k = 0; k < n; k++) begin
            chk_all($sformatf("elem%0d", k), 1'b1, q[k], 1'b1, 1'b0);
            dly = $urandom_range(0, 2);
            if (mid_start && k == 2) begin
                hif.start         = 1'b1;
                hif.matrix_result = rand_mat();
                hif.matrix_size   = 2'($urandom);
                dly = 2;
            end
            for (int c = 0; c < dly; c++) begin
                @(negedge clk);
                hif.start = 1'b0;
                chk_all($sformatf("elem%0d_stall", k), 1'b1, q[k], 1'b1, 1'b0);
            end
            hif.hps_ack = 1'b1;
            @(negedge clk);
            chk_all($sformatf("ackhi%0d", k), 1'b0, 8'h00, 1'b1, 1'b0);
            hold = (k == 0) ? hold0 : $urandom_range(0, 2);
            for (int c = 0; c < hold; c++) begin
                @(negedge clk);
                chk_all($sformatf("ackhold%0d", k), 1'b0, 8'h00, 1'b1, 1'b0);
            end
            hif.hps_ack = 1'b0;
            @(negedge clk);
        end
        chk_all("done_cycle", 1'b0, 8'h00, 1'b1, 1'b1);
        @(negedge clk);
        chk_all("after_done", 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic run_xfer(input logic [1:0] sz, input logic [199:0] mat,
                            input int hold0, input bit mid_start);
        hif.start         = 1'b1;
        hif.matrix_size   = sz;
        hif.matrix_result = mat;
        @(negedge clk);
        hif.start         = 1'b0;
        hif.matrix_result = rand_mat();
        hif.matrix_size   = 2'($urandom);
        serve(sz, mat, hold0, mid_start);
    endtask

    initial begin
        logic [199:0] m;
        vectors           = 0;
        miscompares       = 0;
        rst_n             = 1'b0;
        hif.start         = 1'b0;
        hif.matrix_size   = 2'b00;
        hif.matrix_result = 200'd0;
        hif.hps_ack       = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_all("reset", 1'b0, 8'h00, 1'b0, 1'b0);

        // First rising edge after release samples the start
        rst_n = 1'b1;
        m = {72'h010203040506070809, 128'd0};
        run_xfer(2'b01, m, 0, 1'b0);

        run_xfer(2'b00, rand_mat(), 1, 1'b0);

        m = 200'd0;
        for (int i = 0; i < 25; i++) m[199 - 8*i -: 8] = 8'(i + 1);
        run_xfer(2'b11, m, 0, 1'b0);

        run_xfer(2'b01, rand_mat(), 0, 1'b1);
        run_xfer(2'b01, rand_mat(), 20, 1'b0);

        m = {8'h80, 8'hFF, 8'h7F, 8'h00, 168'd0};
        run_xfer(2'b00, m, 0, 1'b0);

        for (int t = 0; t < 8; t++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_xfer(2'($urandom), rand_mat(), $urandom_range(0, 3), 1'($urandom));
        end

        // Abort a 4x4 transfer while its 5th element is valid
        m = rand_mat();
        hif.start         = 1'b1;
        hif.matrix_size   = 2'b10;
        hif.matrix_result = m;
        @(negedge clk);
        hif.start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk_all($sformatf("abort_elem%0d", k), 1'b1, m[199 - 8*k -: 8], 1'b1, 1'b0);
            hif.hps_ack = 1'b1;
            @(negedge clk);
            hif.hps_ack = 1'b0;
            @(negedge clk);
        end
        chk_all("abort_elem4", 1'b1, m[167:160], 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1 chk_all("async_reset", 1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        chk_all("reset_held", 1'b0, 8'h00, 1'b0, 1'b0);
        m = rand_mat();
        rst_n             = 1'b1;
        hif.start         = 1'b1;
        hif.matrix_size   = 2'b00;
        hif.matrix_result = m;
        @(negedge clk);
        hif.start         = 1'b0;
        hif.matrix_result = rand_mat();
        serve(2'b00, m, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
